// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one input bit per clock.
// Define BIN2BCD_BLANK_EN to enable the registered leading-zero blank mask on digit_blank.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic [DIGITS-1:0]     digit_blank
);
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [DW-1:0]    dig_q, dig_d;
    logic             ovf_s_q, ovf_s_d;
    logic [DW-1:0]    bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic [DW-1:0]    adj;
    logic             capture;

    // Digits never exceed 9, so +3 stays within 4 bits.
    always_comb begin
        adj = dig_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
        end
    end

    assign capture = (state_q == SHIFT) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        dig_d   = dig_q;
        ovf_s_d = ovf_s_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    bin_d   = bin_in;
                    dig_d   = '0;
                    ovf_s_d = 1'b0;
                    cnt_d   = CW'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    bcd_d   = dig_q;
                    ovf_d   = ovf_s_q;
                    state_d = DONE;
                end else begin
                    dig_d = {adj[DW-2:0], bin_q[BIN_W-1]};
                    bin_d = {bin_q[BIN_W-2:0], 1'b0};
                    if (adj[DW-1])
                        ovf_s_d = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            dig_q   <= '0;
            ovf_s_q <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            dig_q   <= dig_d;
            ovf_s_q <= ovf_s_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_nxt;
    logic              allz;

    // Scan from the top digit down; digit 0 always stays visible.
    always_comb begin
        blank_nxt = '0;
        allz      = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            allz         = allz & (dig_q[4*i +: 4] == 4'd0);
            blank_nxt[i] = allz;
        end
        blank_d = capture ? blank_nxt : blank_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) blank_q <= '0;
        else     blank_q <= blank_d;
    end

    assign digit_blank = blank_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign digit_blank    = '0;
`endif

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: arithmetic reference model, per-cycle compare, directed literals.
module tb_bin2bcd_seq;
    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int DW     = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [BIN_W-1:0]  bin_in = '0;
    logic              busy, done, ovf;
    logic [DW-1:0]     bcd_out;
    logic [DIGITS-1:0] digit_blank;

    int total = 0;
    int bad   = 0;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf),
        .digit_blank(digit_blank)
    );

    always #5 clk = ~clk;

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [DW-1:0] bcd_of(input longint v);
        logic [DW-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] blank_of(input longint v);
        logic [DIGITS-1:0] r = '0;
`ifdef BIN2BCD_BLANK_EN
        longint m = v % pow10(DIGITS);
        for (int i = 1; i < DIGITS; i++) r[i] = (m < pow10(i));
`endif
        return r;
    endfunction

    // Reference model: a conversion occupies BIN_W+1 cycles, then one done cycle.
    int                m_cnt = 0;
    longint            m_val = 0;
    logic              m_done = 1'b0;
    logic [DW-1:0]     m_bcd = '0;
    logic              m_ovf = 1'b0;
    logic [DIGITS-1:0] m_blank = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0; m_done <= 1'b0; m_bcd <= '0; m_ovf <= 1'b0; m_blank <= '0;
        end else if (m_cnt == 0) begin
            m_done <= 1'b0;
            if (start) begin
                m_val <= longint'(bin_in);
                m_cnt <= BIN_W + 1;
            end
        end else begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1);
            if (m_cnt == 1) begin
                m_bcd   <= bcd_of(m_val);
                m_ovf   <= (m_val >= pow10(DIGITS));
                m_blank <= blank_of(m_val);
            end
        end
    end

    always @(negedge clk) begin
        total++;
        if ({busy, done, bcd_out, ovf, digit_blank} !==
            {(m_cnt != 0), m_done, m_bcd, m_ovf, m_blank}) begin
            bad++;
            $display("FAIL cycle t=%0t busy=%b/%b done=%b/%b bcd=%h/%h ovf=%b/%b blank=%b/%b (got/exp)",
                     $time, busy, (m_cnt != 0), done, m_done, bcd_out, m_bcd, ovf, m_ovf,
                     digit_blank, m_blank);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk); lat++; @(negedge clk);
        end
    endtask

    task automatic convert(input int unsigned v, output int lat);
        start = 1'b1; bin_in = v[BIN_W-1:0];
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        wait_done(lat);
    endtask

    function automatic logic [DIGITS-1:0] exp_blank(input logic [DIGITS-1:0] b);
`ifdef BIN2BCD_BLANK_EN
        return b;
`else
        return (b & '0);
`endif
    endfunction

    int lat, dcnt;
    int unsigned v;

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd",  64'(bcd_out), 64'd0);
        chk("rst_ovf",  64'(ovf), 64'd0);
        chk("rst_blank", 64'(digit_blank), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        convert(9999, lat);
        chk("lat_9999", 64'(lat), 64'd15);
        chk("bcd_9999", 64'(bcd_out), 64'h9999);
        chk("ovf_9999", 64'(ovf), 64'd0);
        chk("blank_9999", 64'(digit_blank), 64'(exp_blank(4'b0000)));
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);

        convert(0, lat);
        chk("bcd_0", 64'(bcd_out), 64'h0000);
        chk("ovf_0", 64'(ovf), 64'd0);
        chk("blank_0", 64'(digit_blank), 64'(exp_blank(4'b1110)));

        convert(42, lat);
        chk("bcd_42", 64'(bcd_out), 64'h0042);
        chk("blank_42", 64'(digit_blank), 64'(exp_blank(4'b1100)));

        convert(16383, lat);
        chk("bcd_16383", 64'(bcd_out), 64'h6383);
        chk("ovf_16383", 64'(ovf), 64'd1);
        convert(5, lat);
        chk("bcd_5", 64'(bcd_out), 64'h0005);
        chk("ovf_5", 64'(ovf), 64'd0);

        // Start ignored while busy; bin_in wiggles during SHIFT.
        start = 1'b1; bin_in = 14'd123;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; bin_in = 14'd999;
        @(negedge clk);
        start = 1'b0; bin_in = 14'h2aaa;
        dcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("ignored_done_cnt", 64'(dcnt), 64'd1);
        chk("bcd_123", 64'(bcd_out), 64'h0123);

        // Back-to-back: start held through DONE.
        convert(300, lat);
        start = 1'b1; bin_in = 14'd77;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done(lat);
        chk("lat_77", 64'(lat), 64'd15);
        chk("bcd_77", 64'(bcd_out), 64'h0077);

        // Reset mid-SHIFT aborts with all outputs cleared.
        start = 1'b1; bin_in = 14'd1234;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_bcd", 64'(bcd_out), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        chk("mid_rst_blank", 64'(digit_blank), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("mid_rst_no_done", 64'(dcnt), 64'd0);
        convert(5, lat);
        chk("post_rst_lat", 64'(lat), 64'd15);
        chk("post_rst_bcd", 64'(bcd_out), 64'h0005);

        // Random traffic: random starts and bin_in noise while busy, occasional back-to-back.
        for (int i = 0; i < 40; i++) begin
            v = (i % 8 == 0) ? 32'd16383 : $urandom_range(0, 16383);
            start = 1'b1; bin_in = v[BIN_W-1:0];
            @(posedge clk); @(negedge clk);
            lat = 0;
            while (!done && lat < 60) begin
                start  = 1'($urandom_range(0, 1));
                bin_in = BIN_W'($urandom);
                @(posedge clk); lat++; @(negedge clk);
            end
            start = 1'($urandom_range(0, 3) == 0);
            bin_in = BIN_W'($urandom);
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
